// File: rtl/shift_job_arbiter.sv
// Round-robin job scheduler sharing one 4-bit rotator between two requesters.
// Each job rotates its operand once per cycle for a programmed number of steps.
module barrel_shifter (
  input  logic [3:0] i_data,
  input  logic [1:0] i_amt,
  input  logic       i_dir,
  output logic [3:0] o_data
);
  logic [7:0] w_dbl;
  logic [7:0] w_shl;
  logic [7:0] w_shr;

  // Shifting a doubled copy turns a plain shift into a mod-4 rotation.
  always_comb begin
    w_dbl  = {i_data, i_data};
    w_shl  = w_dbl << i_amt;
    w_shr  = w_dbl >> i_amt;
    o_data = i_dir ? w_shr[3:0] : w_shl[7:4];
  end
endmodule

module shift_job_arbiter #(
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_data,
  input  logic [1:0]        req0_amt,
  input  logic              req0_dir,
  input  logic [STEP_W-1:0] req0_steps,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_data,
  input  logic [1:0]        req1_amt,
  input  logic              req1_dir,
  input  logic [STEP_W-1:0] req1_steps,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [3:0]        res_data,
  output logic              res_id,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_acc;
  logic [1:0]        r_amt;
  logic              r_dir;
  logic [STEP_W-1:0] r_cnt;
  logic              r_res_id;
  logic              r_last_grant;

  logic              w_any;
  logic              w_grant;
  logic              w_accept;
  logic [3:0]        w_sel_data;
  logic [1:0]        w_sel_amt;
  logic              w_sel_dir;
  logic [STEP_W-1:0] w_sel_steps;
  logic [3:0]        w_rot;

  barrel_shifter u_shifter (
    .i_data (r_acc),
    .i_amt  (r_amt),
    .i_dir  (r_dir),
    .o_data (w_rot)
  );

  // On contention the requester that did not win last time gets the grant.
  always_comb begin
    w_any       = req0_valid | req1_valid;
    w_grant     = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
    w_accept    = (r_state == IDLE) & w_any;
    w_sel_data  = w_grant ? req1_data  : req0_data;
    w_sel_amt   = w_grant ? req1_amt   : req0_amt;
    w_sel_dir   = w_grant ? req1_dir   : req0_dir;
    w_sel_steps = w_grant ? req1_steps : req0_steps;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = (w_sel_steps == '0) ? DONE : RUN;
      RUN:  if (r_cnt == STEP_W'(1)) w_next = DONE;
      DONE: if (res_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_acc        <= '0;
      r_amt        <= '0;
      r_dir        <= 1'b0;
      r_cnt        <= '0;
      r_res_id     <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_acc        <= w_sel_data;
            r_amt        <= w_sel_amt;
            r_dir        <= w_sel_dir;
            r_cnt        <= w_sel_steps;
            r_res_id     <= w_grant;
            r_last_grant <= w_grant;
          end
        end
        RUN: begin
          r_acc <= w_rot;
          r_cnt <= r_cnt - STEP_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req0_ready = w_accept & ~w_grant;
    req1_ready = w_accept & w_grant;
    res_valid  = (r_state == DONE);
    res_data   = r_acc;
    res_id     = r_res_id;
    busy       = (r_state != IDLE);
  end
endmodule

// File: tb/tb_shift_job_arbiter.sv
// Directed and randomized checks of shift_job_arbiter against a rotation/arbitration reference model.
module tb_shift_job_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [3:0] f_data [2];
  logic [1:0] f_amt  [2];
  logic       f_dir  [2];
  logic [3:0] f_steps[2];
  logic       res_valid, res_ready = 1'b0;
  logic [3:0] res_data;
  logic       res_id, busy;

  int checks = 0;
  int failures = 0;
  int m_last = 1;

  always #5 clk = ~clk;

  shift_job_arbiter #(.STEP_W(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(f_data[0]),
    .req0_amt(f_amt[0]), .req0_dir(f_dir[0]), .req0_steps(f_steps[0]),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(f_data[1]),
    .req1_amt(f_amt[1]), .req1_dir(f_dir[1]), .req1_steps(f_steps[1]),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_id(res_id), .busy(busy)
  );

  // Net effect of a job: one rotation by (steps*amt) mod 4.
  function automatic logic [31:0] model_rot(input int d, input int amt, input int dir, input int steps);
    int k;
    int r;
    k = (steps * amt) % 4;
    if (dir == 0) r = ((d << k) | (d >> (4 - k))) & 15;
    else          r = ((d >> k) | (d << (4 - k))) & 15;
    return 32'(r);
  endfunction

  function automatic int model_grant(input bit v0, input bit v1);
    if (v0 && v1) return (m_last == 0) ? 1 : 0;
    return v1 ? 1 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready = 1'b0;
    step();
    reset = 1'b0;
    m_last = 1;
  endtask

  task automatic set_fields(input int id, input int d, input int a, input int dir, input int s);
    f_data[id]  = 4'(d);
    f_amt[id]   = 2'(a);
    f_dir[id]   = 1'(dir);
    f_steps[id] = 4'(s);
  endtask

  task automatic rand_fields(input int id, input int max_steps);
    set_fields(id, $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 1),
               $urandom_range(0, max_steps));
  endtask

  // Wait for the result, returning the number of edges after the accept edge.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!res_valid && lat < 40) begin
      check("run_ready0", req0_ready, 0);
      check("run_ready1", req1_ready, 0);
      step();
      lat++;
    end
  endtask

  // One job: present valids, check grant, accept, check latency/result, hold, handshake.
  task automatic job(input bit v0, input bit v1, input int hold);
    int g, lat, s;
    logic [31:0] exp;
    req0_valid = v0;
    req1_valid = v1;
    #1;
    g = model_grant(v0, v1);
    check("grant_ready0", req0_ready, (v0 || v1) && g == 0);
    check("grant_ready1", req1_ready, (v0 || v1) && g == 1);
    s   = int'(f_steps[g]);
    exp = model_rot(int'(f_data[g]), int'(f_amt[g]), int'(f_dir[g]), s);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    m_last = g;
    wait_result(lat);
    check("latency", lat, s);
    check("res_valid", res_valid, 1);
    check("res_data", res_data, exp);
    check("res_id", res_id, g);
    check("busy_done", busy, 1);
    req0_valid = (hold > 0);
    req1_valid = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      step();
      check("hold_valid", res_valid, 1);
      check("hold_data", res_data, exp);
      check("hold_id", res_id, g);
      check("hold_ready0", req0_ready, 0);
      check("hold_ready1", req1_ready, 0);
      check("hold_busy", busy, 1);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("post_valid", res_valid, 0);
    check("post_busy", busy, 0);
  endtask

  initial begin
    int g, lat, s;
    logic [31:0] exp;
    set_fields(0, 0, 0, 0, 0);
    set_fields(1, 0, 0, 0, 0);
    step();
    do_reset();
    check("rst_valid", res_valid, 0);
    check("rst_data", res_data, 0);
    check("rst_id", res_id, 0);
    check("rst_busy", busy, 0);
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);

    set_fields(0, 4'b1001, 1, 0, 1);
    job(1, 0, 0);
    set_fields(1, 4'b0001, 2, 1, 3);
    job(0, 1, 0);
    set_fields(0, 4'b1010, 2, 1, 0);
    job(1, 0, 0);
    set_fields(0, 4'b1010, 0, 0, 5);
    job(1, 0, 5);

    // Both requesters continuously valid: strict alternation starting with req0.
    do_reset();
    rand_fields(0, 3);
    rand_fields(1, 3);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      g = model_grant(1, 1);
      check("alt_ready0", req0_ready, g == 0);
      check("alt_ready1", req1_ready, g == 1);
      s   = int'(f_steps[g]);
      exp = model_rot(int'(f_data[g]), int'(f_amt[g]), int'(f_dir[g]), s);
      step();
      m_last = g;
      rand_fields(g, 3);
      wait_result(lat);
      check("alt_latency", lat, s);
      check("alt_order", res_id, i % 2);
      check("alt_data", res_data, exp);
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();

    // Reset in the middle of a long job discards it and restores req0 priority.
    do_reset();
    set_fields(0, 4'b0110, 1, 0, 10);
    req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    repeat (4) step();
    check("midrun_busy", busy, 1);
    check("midrun_valid", res_valid, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_last = 1;
    check("midrst_busy", busy, 0);
    check("midrst_valid", res_valid, 0);
    check("midrst_data", res_data, 0);
    check("midrst_id", res_id, 0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check("midrst_ready0", req0_ready, 1);
    check("midrst_ready1", req1_ready, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();

    for (int i = 0; i < 20; i++) begin
      int pat;
      pat = $urandom_range(1, 3);
      rand_fields(0, 15);
      rand_fields(1, 15);
      job(pat[0], pat[1], $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
